// File: rtl/ram_pkg.sv
// Shared sizes and word/address types for the 256 x 16 CPU RAM.
package ram_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage : ram_pkg

// File: rtl/ram_if.sv
// Access bus between the RAM wrapper (master) and the storage array (slave).
interface ram_if
    import ram_pkg::*;
();

    logic  we;
    word_t data_in;
    addr_t addr;
    // Unregistered array read data; the wrapper owns the output register.
    word_t rdata;

    modport master (
        output we,
        output data_in,
        output addr,
        input  rdata
    );

    modport slave (
        input  we,
        input  data_in,
        input  addr,
        output rdata
    );

endinterface : ram_if

// File: rtl/ram_array.sv
// Word storage with its synchronous write port; read data leaves unregistered.
module ram_array
    import ram_pkg::*;
(
    input logic   clk,
    ram_if.slave  bus
);

    word_t mem [DEPTH];

    // No reset here: contents must survive rst, and a resettable array
    // would not map onto block RAM.
    always_ff @(posedge clk) begin
        if (bus.we) begin
            mem[bus.addr] <= bus.data_in;
        end
    end

    assign bus.rdata = mem[bus.addr];

endmodule : ram_array

// File: rtl/ram.sv
// Single-port 256 x 16 RAM: synchronous write, read-first, 1-cycle registered read.
module ram
    import ram_pkg::*;
(
    input  logic  we,
    input  logic  clk,
    input  word_t data_in,
    input  addr_t addr,
    output word_t data_out,
    input  logic  rst
);

    ram_if bus_if ();

    assign bus_if.we      = we;
    assign bus_if.data_in = data_in;
    assign bus_if.addr    = addr;

    ram_array u_array (
        .clk (clk),
        .bus (bus_if.slave)
    );

    word_t data_out_d;
    word_t data_out_q;

    // Array read sees pre-write contents at the edge, giving read-first.
    always_comb begin
        data_out_d = bus_if.rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

endmodule : ram

// File: tb/tb_ram.sv
// Randomised and directed checks of ram against an array-based reference model.
module tb_ram;
    import ram_pkg::*;

    logic clk;
    logic rst;
    ram_if bus ();

    int vectors;
    int miscompares;

    word_t ref_mem [DEPTH];

    ram dut (
        .we       (bus.we),
        .clk      (clk),
        .data_in  (bus.data_in),
        .addr     (bus.addr),
        .data_out (bus.rdata),
        .rst      (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of access; exp is what data_out must show after this edge.
    task automatic cycle(input logic w, input addr_t a, input word_t d, output word_t exp);
        bus.we      = w;
        bus.addr    = a;
        bus.data_in = d;
        exp = rst ? '0 : ref_mem[a];
        if (w) ref_mem[a] = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_state();
        word_t exp;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.rdata !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_state: data_out=%h expected 0000", bus.rdata);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'(i), 16'h0000, exp);
            vectors++;
            if (bus.rdata !== exp) begin
                miscompares++;
                $display("FAIL reset_hold: data_out=%h expected %h", bus.rdata, exp);
            end
        end
        rst = 1'b0;
        $display("reset state checked");
    endtask

    task automatic test_fill();
        word_t exp;
        word_t want;
        for (int k = 0; k < DEPTH; k++) begin
            cycle(1'b1, 8'(k), 16'(k * 20), exp);
        end
        for (int k = 0; k < DEPTH; k++) begin
            cycle(1'b0, 8'(k), 16'h0000, exp);
            want = 16'(k * 20);
            vectors++;
            if (bus.rdata !== want || exp !== want) begin
                miscompares++;
                $display("FAIL fill_readback addr=%0d: data_out=%0d expected %0d", k, bus.rdata, want);
            end
        end
        $display("fill/readback of %0d words checked", DEPTH);
    endtask

    task automatic test_reset_midrun();
        word_t exp;
        cycle(1'b0, 8'd5, 16'h0000, exp);
        vectors++;
        if (bus.rdata !== 16'd100) begin
            miscompares++;
            $display("FAIL reset_pre: data_out=%0d expected 100", bus.rdata);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (bus.rdata !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_async: data_out=%h expected 0000", bus.rdata);
        end
        cycle(1'b0, 8'd5, 16'h0000, exp);
        vectors++;
        if (bus.rdata !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_held: data_out=%h expected 0000", bus.rdata);
        end
        rst = 1'b0;
        cycle(1'b0, 8'd5, 16'h0000, exp);
        vectors++;
        if (bus.rdata !== 16'd100) begin
            miscompares++;
            $display("FAIL reset_release: data_out=%0d expected 100", bus.rdata);
        end
        $display("reset mid-operation: release read %0d", bus.rdata);
    endtask

    task automatic test_read_first();
        word_t exp;
        cycle(1'b1, 8'd7, 16'h0140, exp);
        cycle(1'b1, 8'd7, 16'hBEEF, exp);
        vectors++;
        if (bus.rdata !== 16'h0140) begin
            miscompares++;
            $display("FAIL read_first_old: data_out=%h expected 0140", bus.rdata);
        end
        cycle(1'b0, 8'd7, 16'h0000, exp);
        vectors++;
        if (bus.rdata !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL read_first_new: data_out=%h expected beef", bus.rdata);
        end
        $display("read-first on addr 7 checked");
    endtask

    task automatic test_overwrite();
        word_t exp;
        cycle(1'b1, 8'd0, 16'h1234, exp);
        cycle(1'b1, 8'd0, 16'hFFFF, exp);
        cycle(1'b0, 8'd0, 16'h0000, exp);
        vectors++;
        if (bus.rdata !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL overwrite: data_out=%h expected ffff", bus.rdata);
        end
        cycle(1'b0, 8'd1, 16'h0000, exp);
        vectors++;
        if (bus.rdata !== 16'd20) begin
            miscompares++;
            $display("FAIL overwrite_neighbour: data_out=%0d expected 20", bus.rdata);
        end
        $display("overwrite of addr 0 checked");
    endtask

    task automatic test_boundaries();
        word_t exp;
        cycle(1'b1, 8'd0,   16'h0000, exp);
        cycle(1'b1, 8'd255, 16'hFFFF, exp);
        cycle(1'b0, 8'd0,   16'h0000, exp);
        vectors++;
        if (bus.rdata !== 16'h0000) begin
            miscompares++;
            $display("FAIL boundary_addr0: data_out=%h expected 0000", bus.rdata);
        end
        cycle(1'b0, 8'd255, 16'h0000, exp);
        vectors++;
        if (bus.rdata !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL boundary_addr255: data_out=%h expected ffff", bus.rdata);
        end
        $display("boundary addresses checked");
    endtask

    task automatic test_reset_during_write();
        word_t exp;
        rst = 1'b1;
        cycle(1'b1, 8'd10, 16'hA5A5, exp);
        vectors++;
        if (bus.rdata !== 16'h0000) begin
            miscompares++;
            $display("FAIL rst_write_out: data_out=%h expected 0000", bus.rdata);
        end
        cycle(1'b1, 8'd11, 16'h5A5A, exp);
        rst = 1'b0;
        cycle(1'b1, 8'd12, 16'hC3C3, exp);
        cycle(1'b0, 8'd10, 16'h0000, exp);
        vectors++;
        if (bus.rdata !== 16'hA5A5) begin
            miscompares++;
            $display("FAIL rst_write_10: data_out=%h expected a5a5", bus.rdata);
        end
        cycle(1'b0, 8'd11, 16'h0000, exp);
        vectors++;
        if (bus.rdata !== 16'h5A5A) begin
            miscompares++;
            $display("FAIL rst_write_11: data_out=%h expected 5a5a", bus.rdata);
        end
        cycle(1'b0, 8'd12, 16'h0000, exp);
        vectors++;
        if (bus.rdata !== 16'hC3C3) begin
            miscompares++;
            $display("FAIL rst_write_12: data_out=%h expected c3c3", bus.rdata);
        end
        $display("writes under reset checked");
    endtask

    task automatic test_random();
        word_t exp;
        logic  w;
        addr_t a;
        word_t d;
        int    bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 8'($urandom_range(0, DEPTH - 1));
            d = 16'($urandom);
            cycle(w, a, d, exp);
            vectors++;
            if (bus.rdata !== exp) begin
                miscompares++;
                bad++;
                $display("FAIL random_%0d we=%b addr=%0d: data_out=%h expected %h", i, w, a, bus.rdata, exp);
            end
        end
        $display("random traffic: 400 cycles, %0d bad", bad);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        bus.we      = 1'b0;
        bus.addr    = '0;
        bus.data_in = '0;
        test_reset_state();
        test_fill();
        test_reset_midrun();
        test_read_first();
        test_overwrite();
        test_boundaries();
        test_reset_during_write();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_ram
